// File: rtl/fetch_cycle_pkg.sv
// Shared definitions for the fetch stage: bubble encoding, predictor reset value,
// instruction field positions and the 2-bit saturating counter rule.
package fetch_cycle_pkg;

  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;
  localparam logic [1:0]  PHT_INIT     = 2'b01;

  localparam int OP_LSB    = 26;
  localparam int RS1_LSB   = 21;
  localparam int RS2_LSB   = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;

  function automatic logic [1:0] sat_count(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'd1;
    return (ctr == 2'b00) ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/fetch_predictor.sv
// Branch predictor: 2-bit PHT, optional global history (FETCH_GSHARE_EN) and a
// direct-mapped BTB. Lookup is combinational; training is applied at the clock edge.
module fetch_predictor
  import fetch_cycle_pkg::*;
#(
  parameter int PC_W      = 5,
  parameter int GHR_W     = 4,
  parameter int BTB_IDX_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PC_W-1:0]      lookup_pc_i,
  output logic                 pred_o,
  output logic                 hit_o,
  output logic [PC_W-1:0]      target_o,
  output logic [GHR_W-1:0]     ghr_o,
  input  logic                 upd_valid_i,
  input  logic [PC_W-1:0]      upd_pc_i,
  input  logic [GHR_W-1:0]     upd_index_i,
  input  logic                 upd_taken_i,
  input  logic [PC_W-1:0]      upd_target_i
);

  localparam int TAG_W = PC_W - BTB_IDX_W;
  localparam int PHT_D = 2 ** GHR_W;
  localparam int BTB_D = 2 ** BTB_IDX_W;

  logic [1:0]       pht_q [PHT_D];
  logic [1:0]       pht_d [PHT_D];
  logic [BTB_D-1:0] btb_valid_q, btb_valid_d;
  logic [TAG_W-1:0] btb_tag_q [BTB_D];
  logic [TAG_W-1:0] btb_tag_d [BTB_D];
  logic [PC_W-1:0]  btb_tgt_q [BTB_D];
  logic [PC_W-1:0]  btb_tgt_d [BTB_D];

  logic [GHR_W-1:0]     lookup_idx;
  logic [BTB_IDX_W-1:0] lookup_slot, upd_slot;

`ifdef FETCH_GSHARE_EN
  logic [GHR_W-1:0] ghr_q, ghr_d;

  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid_i) ghr_d = {ghr_q[GHR_W-2:0], upd_taken_i};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ghr_q <= '0;
    else       ghr_q <= ghr_d;
  end

  assign ghr_o      = ghr_q;
  assign lookup_idx = lookup_pc_i[GHR_W-1:0] ^ ghr_q;
`else
  assign ghr_o      = '0;
  assign lookup_idx = lookup_pc_i[GHR_W-1:0];
`endif

  assign lookup_slot = lookup_pc_i[BTB_IDX_W-1:0];
  assign upd_slot    = upd_pc_i[BTB_IDX_W-1:0];

  // Lookup reads the _q arrays, so a same-cycle update is only visible next cycle.
  assign pred_o   = pht_q[lookup_idx][1];
  assign hit_o    = btb_valid_q[lookup_slot] &&
                    (btb_tag_q[lookup_slot] == lookup_pc_i[PC_W-1:BTB_IDX_W]);
  assign target_o = btb_tgt_q[lookup_slot];

  always_comb begin
    pht_d       = pht_q;
    btb_valid_d = btb_valid_q;
    btb_tag_d   = btb_tag_q;
    btb_tgt_d   = btb_tgt_q;
    if (upd_valid_i) begin
      pht_d[upd_index_i] = sat_count(pht_q[upd_index_i], upd_taken_i);
      if (upd_taken_i) begin
        btb_valid_d[upd_slot] = 1'b1;
        btb_tag_d[upd_slot]   = upd_pc_i[PC_W-1:BTB_IDX_W];
        btb_tgt_d[upd_slot]   = upd_target_i;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PHT_D; i++) pht_q[i] <= PHT_INIT;
      for (int i = 0; i < BTB_D; i++) begin
        btb_tag_q[i] <= '0;
        btb_tgt_q[i] <= '0;
      end
      btb_valid_q <= '0;
    end else begin
      pht_q       <= pht_d;
      btb_valid_q <= btb_valid_d;
      btb_tag_q   <= btb_tag_d;
      btb_tgt_q   <= btb_tgt_d;
    end
  end

endmodule

// File: rtl/fetch_cycle.sv
// Instruction fetch stage with IF/ID register and branch prediction. Build option:
// FETCH_GSHARE_EN selects gshare indexing; imem is a ROM preloaded by the environment.
module fetch_cycle
  import fetch_cycle_pkg::*;
#(
  parameter int PC_W      = 5,
  parameter int GHR_W     = 4,
  parameter int BTB_IDX_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              flush_JR,
  input  logic [PC_W-1:0]   fix_pc,
  input  logic [PC_W-1:0]   jr_pc,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic [GHR_W-1:0]  upd_index,
  input  logic              upd_taken,
  input  logic [PC_W-1:0]   upd_target,
  output logic [5:0]        Op,
  output logic [5:0]        functI,
  output logic [4:0]        rs1_F,
  output logic [4:0]        rs2_F,
  output logic [4:0]        rd_F,
  output logic [4:0]        shamtI,
  output logic [15:0]       imm,
  output logic [PC_W-1:0]   pc,
  output logic [GHR_W-1:0]  GHR_value,
  output logic              hit,
  output logic              prediction
);

  logic [31:0] imem [2**PC_W];

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [31:0]      id_instr_q, id_instr_d;
  logic [PC_W-1:0]  id_pc_q, id_pc_d;
  logic [GHR_W-1:0] id_ghr_q, id_ghr_d;
  logic             id_hit_q, id_hit_d;
  logic             id_pred_q, id_pred_d;

  logic             bp_pred, bp_hit;
  logic [PC_W-1:0]  bp_target;
  logic [GHR_W-1:0] bp_ghr;

  fetch_predictor #(
    .PC_W(PC_W), .GHR_W(GHR_W), .BTB_IDX_W(BTB_IDX_W)
  ) u_pred (
    .clk          (clk),
    .reset        (reset),
    .lookup_pc_i  (pc_q),
    .pred_o       (bp_pred),
    .hit_o        (bp_hit),
    .target_o     (bp_target),
    .ghr_o        (bp_ghr),
    .upd_valid_i  (upd_valid),
    .upd_pc_i     (upd_pc),
    .upd_index_i  (upd_index),
    .upd_taken_i  (upd_taken),
    .upd_target_i (upd_target)
  );

  // Redirects from EX beat the stall: the held instruction is on a wrong path anyway.
  always_comb begin
    pc_d       = pc_q + PC_W'(1);
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    id_ghr_d   = id_ghr_q;
    id_hit_d   = id_hit_q;
    id_pred_d  = id_pred_q;

    if (flush)                  pc_d = fix_pc;
    else if (flush_JR)          pc_d = jr_pc;
    else if (stall)             pc_d = pc_q;
    else if (bp_hit && bp_pred) pc_d = bp_target;

    if (flush || flush_JR) begin
      id_instr_d = BUBBLE_INSTR;
      id_pc_d    = '0;
      id_ghr_d   = '0;
      id_hit_d   = 1'b0;
      id_pred_d  = 1'b0;
    end else if (!stall) begin
      id_instr_d = imem[pc_q];
      id_pc_d    = pc_q;
      id_ghr_d   = bp_ghr;
      id_hit_d   = bp_hit;
      id_pred_d  = bp_pred;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= '0;
      id_instr_q <= BUBBLE_INSTR;
      id_pc_q    <= '0;
      id_ghr_q   <= '0;
      id_hit_q   <= 1'b0;
      id_pred_q  <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_ghr_q   <= id_ghr_d;
      id_hit_q   <= id_hit_d;
      id_pred_q  <= id_pred_d;
    end
  end

  assign Op         = id_instr_q[OP_LSB +: 6];
  assign rs1_F      = id_instr_q[RS1_LSB +: 5];
  assign rs2_F      = id_instr_q[RS2_LSB +: 5];
  assign rd_F       = id_instr_q[RD_LSB +: 5];
  assign shamtI     = id_instr_q[SHAMT_LSB +: 5];
  assign functI     = id_instr_q[5:0];
  assign imm        = id_instr_q[15:0];
  assign pc         = id_pc_q;
  assign GHR_value  = id_ghr_q;
  assign hit        = id_hit_q;
  assign prediction = id_pred_q;

endmodule

// File: tb/tb_fetch_cycle.sv
// Self-checking bench for fetch_cycle: directed scenarios plus random traffic, scored
// against an integer-level model of PC sequencing, PHT, GHR and BTB.
module tb_fetch_cycle;

  localparam int PC_W = 5, GHR_W = 4, BTB_IDX_W = 3;
  localparam int W = 59;  // imm(16) + instr(32) + pc(5) + ghr(4) + hit + pred

  logic clk = 1'b0;
  logic reset, stall, flush, flush_JR, upd_valid, upd_taken;
  logic [PC_W-1:0]  fix_pc, jr_pc, upd_pc, upd_target;
  logic [GHR_W-1:0] upd_index;
  logic [5:0]  Op, functI;
  logic [4:0]  rs1_F, rs2_F, rd_F, shamtI;
  logic [15:0] imm;
  logic [PC_W-1:0]  pc;
  logic [GHR_W-1:0] GHR_value;
  logic hit, prediction;

  fetch_cycle #(.PC_W(PC_W), .GHR_W(GHR_W), .BTB_IDX_W(BTB_IDX_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .flush_JR(flush_JR),
    .fix_pc(fix_pc), .jr_pc(jr_pc), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_index(upd_index), .upd_taken(upd_taken), .upd_target(upd_target),
    .Op(Op), .functI(functI), .rs1_F(rs1_F), .rs2_F(rs2_F), .rd_F(rd_F),
    .shamtI(shamtI), .imm(imm), .pc(pc), .GHR_value(GHR_value), .hit(hit),
    .prediction(prediction)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int checks = 0, errors = 0;

  // Reference model state
  logic [31:0]  mem [32];
  int           m_pc, m_ghr;
  int           m_pht [16];
  bit           m_bv [8];
  int           m_btag [8], m_btgt [8];
  logic [W-1:0] m_ifid;

  function automatic logic [W-1:0] pack(logic [31:0] ins, int p, int g, bit h, bit pr);
    logic [4:0] p5;
    logic [3:0] g4;
    p5 = 5'(p);
    g4 = 4'(g);
    return {ins[15:0], ins, p5, g4, h, pr};
  endfunction

  function automatic logic [W-1:0] actual();
    return {imm, Op, rs1_F, rs2_F, rd_F, shamtI, functI, pc, GHR_value, hit, prediction};
  endfunction

  task automatic model_reset();
    m_pc = 0;
    m_ghr = 0;
    m_ifid = '0;
    for (int i = 0; i < 16; i++) m_pht[i] = 1;
    for (int i = 0; i < 8; i++) begin
      m_bv[i] = 0; m_btag[i] = 0; m_btgt[i] = 0;
    end
  endtask

  task automatic model_step();
    int idx, slot, tag, ui;
    bit pr, h;
    if (reset) begin
      model_reset();
    end else begin
`ifdef FETCH_GSHARE_EN
      idx = (m_pc % 16) ^ m_ghr;
`else
      idx = m_pc % 16;
`endif
      pr   = (m_pht[idx] >= 2);
      slot = m_pc % 8;
      tag  = m_pc / 8;
      h    = m_bv[slot] && (m_btag[slot] == tag);
      if (flush || flush_JR) m_ifid = '0;
      else if (!stall)       m_ifid = pack(mem[m_pc], m_pc, m_ghr, h, pr);
      if (flush)         m_pc = int'(fix_pc);
      else if (flush_JR) m_pc = int'(jr_pc);
      else if (stall)    m_pc = m_pc;
      else if (h && pr)  m_pc = m_btgt[slot];
      else               m_pc = (m_pc + 1) % 32;
      if (upd_valid) begin
        ui = int'(upd_index);
        if (upd_taken) begin
          if (m_pht[ui] < 3) m_pht[ui] = m_pht[ui] + 1;
          m_bv[upd_pc % 8]   = 1;
          m_btag[upd_pc % 8] = int'(upd_pc) / 8;
          m_btgt[upd_pc % 8] = int'(upd_target);
        end else if (m_pht[ui] > 0) begin
          m_pht[ui] = m_pht[ui] - 1;
        end
`ifdef FETCH_GSHARE_EN
        m_ghr = (m_ghr * 2 + int'(upd_taken)) % 16;
`endif
      end
    end
    exp_q.push_back(m_ifid);
  endtask

  // Inputs change 1 time unit after the falling edge; outputs are scored on the falling edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; stall = 0; flush = 0; flush_JR = 0;
    fix_pc = '0; jr_pc = '0;
    upd_valid = 0; upd_pc = '0; upd_index = '0; upd_taken = 0; upd_target = '0;
  endtask

  task automatic train(int p, int idx, bit taken, int tgt);
    upd_valid = 1; upd_pc = 5'(p); upd_index = 4'(idx);
    upd_taken = taken; upd_target = 5'(tgt);
  endtask

  always @(negedge clk) begin : monitor
    logic [W-1:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = actual();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL ifid @%0t: got pc=%0d instr=%h imm=%h ghr=%h hit=%b pred=%b, expected pc=%0d instr=%h imm=%h ghr=%h hit=%b pred=%b",
                 $time, a[10:6], a[42:11], a[58:43], a[5:2], a[1], a[0],
                 e[10:6], e[42:11], e[58:43], e[5:2], e[1], e[0]);
      end
    end
  end

  initial begin
    int drain;
    for (int i = 0; i < 32; i++) begin
      mem[i] = $urandom;
      dut.imem[i] = mem[i];
    end
    model_reset();
    idle();
    reset = 1;
    #1;
    tick();
    tick();
    reset = 0;

    // Straight-line fetch across the 31 -> 0 wrap
    repeat (40) tick();

    // Mid-run reset: outputs clear immediately, then fetch restarts at 0
    reset = 1;
    #1;
    checks++;
    if (actual() !== '0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 0", actual());
    end
    tick();
    reset = 0;

    // Reach PC=4, stall three cycles, resume
    repeat (4) tick();
    stall = 1;
    repeat (3) tick();
    stall = 0;
    repeat (2) tick();

    // Flush overrides stall: bubble then fetch at 9
    stall = 1; flush = 1; fix_pc = 5'd9;
    tick();
    idle();
    repeat (3) tick();

    // beq at 6 resolved taken twice toward 12, then fetch through 6
    train(6, 6, 1, 12);
    repeat (2) tick();
    idle();
    flush = 1; fix_pc = 5'd0;
    tick();
    idle();
    repeat (10) tick();

    // Saturating counter on index 3: up to 11, then down to 00 and stays
    reset = 1;
    tick();
    idle();
    train(3, 3, 1, 20);
    repeat (2) tick();
    idle();
    repeat (3) tick();
    train(25, 3, 0, 0);
    repeat (4) tick();
    idle();
    flush = 1; fix_pc = 5'd3;
    tick();
    idle();
    repeat (3) tick();

    // Randomized traffic
    repeat (800) begin
      reset     = ($urandom_range(0, 99) == 0);
      stall     = ($urandom_range(0, 5) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      flush_JR  = ($urandom_range(0, 15) == 0);
      fix_pc    = 5'($urandom_range(0, 31));
      jr_pc     = 5'($urandom_range(0, 31));
      upd_valid = ($urandom_range(0, 2) == 0);
      upd_pc    = 5'($urandom_range(0, 31));
      upd_index = 4'($urandom_range(0, 15));
      upd_taken = ($urandom_range(0, 2) != 0);
      upd_target = 5'($urandom_range(0, 31));
      tick();
    end
    idle();
    repeat (3) tick();

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
